// File: rtl/k_and_s_pkg.sv
// Shared types for the K-and-S control path: decoded instruction set,
// controller states and ALU operation codes.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_BOV,
        I_BNOV,
        I_HALT
    } decoded_instruction_type;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_LOAD_IR,
        ST_DECODE,
        ST_EXEC_ALU,
        ST_MEM_LOAD,
        ST_MEM_STORE,
        ST_BRANCH_TAKEN,
        ST_HALTED,
        ST_FAULT
    } state_t;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // MOVE passes its operand through the OR path, so it shares OP_OR.
    function automatic logic [1:0] alu_op(input decoded_instruction_type instr);
        logic [1:0] op;
        case (instr)
            I_ADD:   op = OP_ADD;
            I_SUB:   op = OP_SUB;
            I_AND:   op = OP_AND;
            default: op = OP_OR;
        endcase
        return op;
    endfunction

    function automatic logic is_mem_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_LOAD) || (s == ST_MEM_STORE);
    endfunction

endpackage

// File: rtl/ks_wait_timer.sv
// Memory-wait cycle counter; flags the last permitted wait cycle so the
// controller can abandon a stuck access.
module ks_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] LIMIT = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Saturate rather than wrap so a disabled timeout never aliases back to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (tick && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/ks_ctrl_fsm.sv
// Multi-cycle controller for the K-and-S core: fetch/decode/execute
// sequencing, memory handshakes with timeout, and a retired-instruction count.
module ks_ctrl_fsm
    import k_and_s_pkg::*;
#(
    parameter int OV_SEL  = 0,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    write_reg_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic [1:0]              operation,
    output logic                    halt,
    output logic                    fault,
    output logic [CNT_W-1:0]        instr_count
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ov;
    logic             waitTick;
    logic             waitClr;
    logic             waitExpired;

    assign ov = (OV_SEL != 0) ? signed_overflow : unsigned_overflow;

    // Counter restarts whenever a memory-waiting state is freshly entered.
    assign waitTick = is_mem_wait_state(state_q) && !mem_ready;
    assign waitClr  = is_mem_wait_state(state_d) && (state_d != state_q);

    ks_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (waitClr),
        .tick    (waitTick),
        .expired (waitExpired)
    );

    always_comb begin
        state_d          = state_q;
        mem_req          = 1'b0;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        write_reg_enable = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        operation        = OP_OR;
        halt             = 1'b0;
        fault            = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready)        state_d = ST_LOAD_IR;
                else if (waitExpired) state_d = ST_FAULT;
            end
            ST_LOAD_IR: begin
                ir_enable = 1'b1;
                pc_enable = 1'b1;
                state_d   = ST_DECODE;
            end
            ST_DECODE: begin
                case (decoded_instruction)
                    I_HALT:   state_d = ST_HALTED;
                    I_LOAD:   state_d = ST_MEM_LOAD;
                    I_STORE:  state_d = ST_MEM_STORE;
                    I_MOVE, I_ADD, I_SUB, I_AND, I_OR:
                              state_d = ST_EXEC_ALU;
                    I_BRANCH: state_d = ST_BRANCH_TAKEN;
                    I_BZERO:  state_d = zero_op  ? ST_BRANCH_TAKEN : ST_FETCH;
                    I_BNZERO: state_d = !zero_op ? ST_BRANCH_TAKEN : ST_FETCH;
                    I_BNEG:   state_d = neg_op   ? ST_BRANCH_TAKEN : ST_FETCH;
                    I_BNNEG:  state_d = !neg_op  ? ST_BRANCH_TAKEN : ST_FETCH;
                    I_BOV:    state_d = ov       ? ST_BRANCH_TAKEN : ST_FETCH;
                    I_BNOV:   state_d = !ov      ? ST_BRANCH_TAKEN : ST_FETCH;
                    default:  state_d = ST_FETCH;
                endcase
            end
            ST_EXEC_ALU: begin
                write_reg_enable = 1'b1;
                c_sel            = 1'b1;
                operation        = alu_op(decoded_instruction);
                flags_reg_enable = (decoded_instruction != I_MOVE);
                state_d          = ST_FETCH;
            end
            ST_MEM_LOAD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    write_reg_enable = 1'b1;
                    state_d          = ST_FETCH;
                end else if (waitExpired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_MEM_STORE: begin
                mem_req          = 1'b1;
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
                if (mem_ready)        state_d = ST_FETCH;
                else if (waitExpired) state_d = ST_FAULT;
            end
            ST_BRANCH_TAKEN: begin
                branch    = 1'b1;
                pc_enable = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALTED: begin
                halt = 1'b1;
            end
            ST_FAULT: begin
                halt  = 1'b1;
                fault = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // One retirement per DECODE cycle, pinned at all-ones once full.
    always_comb begin
        count_d = count_q;
        if ((state_q == ST_DECODE) && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;

endmodule

// File: tb/tb_ks_ctrl_fsm.sv
// Scoreboard bench for ks_ctrl_fsm: two instances with different parameters,
// per-cycle expected control vectors queued by stimulus and checked at negedge.
module tb_ks_ctrl_fsm;
    import k_and_s_pkg::*;

    // Control bit order: {mem_req, branch, pc_enable, ir_enable, write_reg_enable,
    // addr_sel, c_sel, flags_reg_enable, ram_write_enable, halt, fault}
    localparam logic [10:0] C_FETCH  = 11'b1_0_0_0_0_0_0_0_0_0_0;
    localparam logic [10:0] C_LOADIR = 11'b0_0_1_1_0_0_0_0_0_0_0;
    localparam logic [10:0] C_DECODE = 11'b0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [10:0] C_EXEC   = 11'b0_0_0_0_1_0_1_1_0_0_0;
    localparam logic [10:0] C_MOVE   = 11'b0_0_0_0_1_0_1_0_0_0_0;
    localparam logic [10:0] C_LDWAIT = 11'b1_0_0_0_0_1_0_0_0_0_0;
    localparam logic [10:0] C_LDDONE = 11'b1_0_0_0_1_1_0_0_0_0_0;
    localparam logic [10:0] C_STORE  = 11'b1_0_0_0_0_1_0_0_1_0_0;
    localparam logic [10:0] C_BRANCH = 11'b0_1_1_0_0_0_0_0_0_0_0;
    localparam logic [10:0] C_HALTED = 11'b0_0_0_0_0_0_0_0_0_1_0;
    localparam logic [10:0] C_FAULT  = 11'b0_0_0_0_0_0_0_0_0_1_1;

    typedef struct {
        int          dut;
        logic [10:0] ctl;
        logic [1:0]  op;
        int          cnt;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rstA;
    logic                    rstB;
    decoded_instruction_type instr;
    logic                    zeroOp;
    logic                    negOp;
    logic                    uOv;
    logic                    sOv;
    logic                    memReady;

    wire [10:0] aCtl;
    wire [1:0]  aOp;
    wire [15:0] aCnt;
    wire [10:0] bCtl;
    wire [1:0]  bOp;
    wire [1:0]  bCnt;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   expCnt = 0;

    ks_ctrl_fsm #(.OV_SEL(0), .TIMEOUT(15), .CNT_W(16)) dutA (
        .clk                 (clk),
        .rst_n               (rstA),
        .decoded_instruction (instr),
        .zero_op             (zeroOp),
        .neg_op              (negOp),
        .unsigned_overflow   (uOv),
        .signed_overflow     (sOv),
        .mem_ready           (memReady),
        .mem_req             (aCtl[10]),
        .branch              (aCtl[9]),
        .pc_enable           (aCtl[8]),
        .ir_enable           (aCtl[7]),
        .write_reg_enable    (aCtl[6]),
        .addr_sel            (aCtl[5]),
        .c_sel               (aCtl[4]),
        .flags_reg_enable    (aCtl[3]),
        .ram_write_enable    (aCtl[2]),
        .operation           (aOp),
        .halt                (aCtl[1]),
        .fault               (aCtl[0]),
        .instr_count         (aCnt)
    );

    ks_ctrl_fsm #(.OV_SEL(1), .TIMEOUT(4), .CNT_W(2)) dutB (
        .clk                 (clk),
        .rst_n               (rstB),
        .decoded_instruction (instr),
        .zero_op             (zeroOp),
        .neg_op              (negOp),
        .unsigned_overflow   (uOv),
        .signed_overflow     (sOv),
        .mem_ready           (memReady),
        .mem_req             (bCtl[10]),
        .branch              (bCtl[9]),
        .pc_enable           (bCtl[8]),
        .ir_enable           (bCtl[7]),
        .write_reg_enable    (bCtl[6]),
        .addr_sel            (bCtl[5]),
        .c_sel               (bCtl[4]),
        .flags_reg_enable    (bCtl[3]),
        .ram_write_enable    (bCtl[2]),
        .operation           (bOp),
        .halt                (bCtl[1]),
        .fault               (bCtl[0]),
        .instr_count         (bCnt)
    );

    // Drive one cycle of inputs and queue what the selected DUT must show in it.
    task automatic applyStimulus(input int d, input logic rstN,
                                 input decoded_instruction_type ins,
                                 input logic [3:0] flags, input logic ready,
                                 input logic [10:0] ctl, input logic [1:0] op,
                                 input int cnt, input string tag);
        exp_t e;
        if (d == 0) rstA = rstN;
        else        rstB = rstN;
        instr = ins;
        {zeroOp, negOp, uOv, sOv} = flags;
        memReady = ready;
        e.dut = d;
        e.ctl = ctl;
        e.op  = op;
        e.cnt = cnt;
        e.tag = tag;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetchDecode(input int d, input decoded_instruction_type ins,
                               input logic [3:0] flags, input int cnt);
        applyStimulus(d, 1'b1, ins, flags, 1'b1, C_FETCH,  2'b00, cnt, "fetch");
        applyStimulus(d, 1'b1, ins, flags, 1'b1, C_LOADIR, 2'b00, cnt, "load_ir");
        applyStimulus(d, 1'b1, ins, flags, 1'b1, C_DECODE, 2'b00, cnt, "decode");
    endtask

    task automatic checkOutput(input exp_t e);
        logic [10:0] ctl;
        logic [1:0]  op;
        int          cnt;
        if (e.dut == 0) begin
            ctl = aCtl; op = aOp; cnt = int'(aCnt);
        end else begin
            ctl = bCtl; op = bOp; cnt = int'(bCnt);
        end
        checks++;
        if (ctl !== e.ctl || op !== e.op || cnt != e.cnt) begin
            errors++;
            $display("[TB] FAIL dut%0d %s @%0t: got ctl=%b op=%b cnt=%0d, expected ctl=%b op=%b cnt=%0d",
                     e.dut, e.tag, $time, ctl, op, cnt, e.ctl, e.op, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    decoded_instruction_type aluIns[5] = '{I_ADD, I_MOVE, I_SUB, I_AND, I_OR};
    logic [1:0]              aluOps[5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
    logic [10:0]             aluCtl[5] = '{C_EXEC, C_MOVE, C_EXEC, C_EXEC, C_EXEC};

    // Flags are {zero, neg, unsigned_ov, signed_ov}; outcomes are for OV_SEL=0.
    decoded_instruction_type brIns[11] = '{I_BOV, I_BNOV, I_BZERO, I_BZERO, I_BNZERO,
                                           I_BNEG, I_BNNEG, I_BNNEG, I_BRANCH, I_BOV, I_NOP};
    logic [3:0]              brFlg[11] = '{4'b0001, 4'b0001, 4'b1000, 4'b0000, 4'b1000,
                                           4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    logic                    brTkn[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                           1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    int cntSeq[5] = '{1, 2, 3, 3, 3};

    initial begin
        rstA = 1'b0;
        rstB = 1'b0;
        instr = I_NOP;
        {zeroOp, negOp, uOv, sOv} = 4'b0000;
        memReady = 1'b1;
        @(posedge clk);
        #1;

        // Instance A: OV_SEL=0, TIMEOUT=15, CNT_W=16
        applyStimulus(0, 1'b0, I_NOP, 4'b0, 1'b1, C_FETCH, 2'b00, 0, "A reset");
        applyStimulus(0, 1'b0, I_NOP, 4'b0, 1'b0, C_FETCH, 2'b00, 0, "A reset");
        expCnt = 0;
        for (int i = 0; i < 5; i++) begin
            fetchDecode(0, aluIns[i], 4'b0, expCnt);
            expCnt++;
            applyStimulus(0, 1'b1, aluIns[i], 4'b0, 1'b1, aluCtl[i], aluOps[i], expCnt, "A exec");
        end
        for (int i = 0; i < 11; i++) begin
            fetchDecode(0, brIns[i], brFlg[i], expCnt);
            expCnt++;
            if (brTkn[i])
                applyStimulus(0, 1'b1, brIns[i], brFlg[i], 1'b1, C_BRANCH, 2'b00, expCnt, "A branch");
        end
        applyStimulus(0, 1'b1, I_NOP, 4'b0, 1'b0, C_FETCH, 2'b00, expCnt, "A fetch wait");
        applyStimulus(0, 1'b1, I_NOP, 4'b0, 1'b0, C_FETCH, 2'b00, expCnt, "A fetch wait");
        fetchDecode(0, I_LOAD, 4'b0, expCnt);
        expCnt++;
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1'b1, I_LOAD, 4'b0, 1'b0, C_LDWAIT, 2'b00, expCnt, "A load wait");
        applyStimulus(0, 1'b1, I_LOAD, 4'b0, 1'b1, C_LDDONE, 2'b00, expCnt, "A load done");
        fetchDecode(0, I_STORE, 4'b0, expCnt);
        expCnt++;
        applyStimulus(0, 1'b1, I_STORE, 4'b0, 1'b0, C_STORE, 2'b00, expCnt, "A store wait");
        applyStimulus(0, 1'b1, I_STORE, 4'b0, 1'b1, C_STORE, 2'b00, expCnt, "A store done");
        fetchDecode(0, I_HALT, 4'b0, expCnt);
        expCnt++;
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1'b1, I_HALT, 4'b0, 1'b0, C_HALTED, 2'b00, expCnt, "A halted");

        // Instance B: OV_SEL=1, TIMEOUT=4, CNT_W=2
        applyStimulus(1, 1'b0, I_NOP, 4'b0, 1'b1, C_FETCH, 2'b00, 0, "B reset");
        fetchDecode(1, I_BOV, 4'b0001, 0);
        applyStimulus(1, 1'b1, I_BOV, 4'b0001, 1'b1, C_BRANCH, 2'b00, cntSeq[0], "B bov taken");
        for (int i = 1; i < 5; i++)
            fetchDecode(1, I_NOP, 4'b0, cntSeq[i-1]);
        fetchDecode(1, I_LOAD, 4'b0, cntSeq[4]);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1'b1, I_LOAD, 4'b0, 1'b0, C_LDWAIT, 2'b00, 3, "B load wait");
        applyStimulus(1, 1'b1, I_LOAD, 4'b0, 1'b1, C_LDDONE, 2'b00, 3, "B ready at limit");
        fetchDecode(1, I_STORE, 4'b0, 3);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1'b1, I_STORE, 4'b0, 1'b0, C_STORE, 2'b00, 3, "B store stuck");
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1'b1, I_STORE, 4'b0, 1'b0, C_FAULT, 2'b00, 3, "B fault");
        applyStimulus(1, 1'b0, I_STORE, 4'b0, 1'b0, C_FETCH, 2'b00, 0, "B reset pulse");
        applyStimulus(1, 1'b1, I_NOP, 4'b0, 1'b1, C_FETCH, 2'b00, 0, "B after reset");
        applyStimulus(1, 1'b1, I_NOP, 4'b0, 1'b1, C_LOADIR, 2'b00, 0, "B after reset");

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ks_ctrl_fsm.md
KS_CTRL_FSM -- requirements
Module: ks_ctrl_fsm

Interface
REQ-001 SHALL have parameter OV_SEL, default 0: BOV/BNOV test unsigned_overflow when 0, signed_overflow when 1.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum memory-wait cycles, range 0..255; 0 disables the timeout.
REQ-003 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-004 SHALL use clock clk and reset rst_n, asynchronous, active-low.
REQ-005 SHALL have ports: clk  in  1  clock.
REQ-006 rst_n  in  1  async active-low reset.
REQ-007 decoded_instruction  in  decoded_instruction_type  current IR decode.
REQ-008 zero_op, neg_op, unsigned_overflow, signed_overflow  in  1 each  registered ALU flags.
REQ-009 mem_ready  in  1  memory completes the current request.
REQ-010 mem_req  out  1  memory request.
REQ-011 branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable, ram_write_enable  out  1 each  datapath controls.
REQ-012 operation  out  2  ALU op: OR=00, ADD=01, SUB=10, AND=11.
REQ-013 halt  out  1  core stopped.
REQ-014 fault  out  1  memory timeout occurred; sticky.
REQ-015 instr_count  out  CNT_W  retired instructions.

Function
REQ-016 SHALL implement states FETCH, LOAD_IR, DECODE, EXEC_ALU, MEM_LOAD, MEM_STORE, BRANCH_TAKEN, HALTED, FAULT.
REQ-017 Unlisted outputs SHALL be 0 in every state.
REQ-018 Outputs SHALL be combinational from state and inputs.
REQ-019 FETCH: mem_req=1, addr_sel=0; stay while mem_ready=0; go to LOAD_IR on mem_ready=1.
REQ-020 LOAD_IR: ir_enable=1, pc_enable=1; go to DECODE next cycle.
REQ-021 DECODE SHALL route as follows:
- HALT to HALTED.
- LOAD to MEM_LOAD; STORE to MEM_STORE.
- MOVE, ADD, SUB, AND, OR to EXEC_ALU.
- BRANCH to BRANCH_TAKEN.
- Conditional branches to BRANCH_TAKEN if the condition is true, else to FETCH.
- Any other encoding to FETCH.
REQ-022 Branch conditions SHALL be:
- BZERO: zero_op. BNZERO: !zero_op.
- BNEG: neg_op. BNNEG: !neg_op.
- BOV: ov. BNOV: !ov, where ov is selected by OV_SEL.
REQ-023 EXEC_ALU: write_reg_enable=1, c_sel=1, operation per REQ-012 (MOVE=00); flags_reg_enable=1 except for MOVE (0); then FETCH.
REQ-024 MEM_LOAD: mem_req=1, addr_sel=1; in the cycle mem_ready=1, write_reg_enable=1 and c_sel=0, then FETCH; else stay.
REQ-025 MEM_STORE: mem_req=1, addr_sel=1, ram_write_enable=1 until the mem_ready=1 cycle inclusive, then FETCH.
REQ-026 BRANCH_TAKEN: branch=1, pc_enable=1; then FETCH.
REQ-027 HALTED: halt=1; remain until reset.
REQ-028 FAULT: halt=1, fault=1; remain until reset.
REQ-029 Wait counter (8 bit) SHALL clear on every entry to FETCH, MEM_LOAD or MEM_STORE.
REQ-030 Wait counter SHALL increment each cycle in those states with mem_ready=0.
REQ-031 If TIMEOUT!=0, mem_ready=0 and counter==TIMEOUT-1, next state SHALL be FAULT (TIMEOUT wait cycles allowed).
REQ-032 mem_ready=1 in the same cycle as the timeout condition SHALL win: normal transition, no fault.
REQ-033 instr_count SHALL increment once per DECODE cycle and saturate at all-ones.
REQ-034 Flag inputs SHALL be sampled only in DECODE.

Reset
REQ-035 rst_n low SHALL force state=FETCH, wait counter=0, instr_count=0 immediately.
REQ-036 Reset output values: mem_req=1 (FETCH decode); all other outputs 0.
REQ-037 Reset mid-access SHALL abandon the access; no write or ram_write occurs after deassertion until a new access.

Structure
REQ-038 State enum and ALU op constants (OP_OR/ADD/SUB/AND) SHALL live in k_and_s_pkg alongside decoded_instruction_type.
REQ-039 Wait/timeout counter SHALL be a sub-module ks_wait_timer (params TIMEOUT; ports clr, tick, expired).

Verification
REQ-040 ADD with mem_ready tied 1 -> FETCH, LOAD_IR, DECODE, EXEC_ALU (4 cycles); operation=01, flags_reg_enable=1; instr_count=1.
REQ-041 MOVE -> EXEC_ALU with write_reg_enable=1, flags_reg_enable=0, operation=00.
REQ-042 BOV with signed_overflow=1, unsigned_overflow=0: OV_SEL=0 -> no branch; OV_SEL=1 -> BRANCH_TAKEN with branch=1, pc_enable=1.
REQ-043 LOAD with mem_ready low 3 cycles (TIMEOUT=15) -> 4 MEM_LOAD cycles; write_reg_enable=1 only in the 4th.
REQ-044 STORE with mem_ready stuck 0, TIMEOUT=4 -> FAULT after 4 wait cycles; halt=1, fault=1 hold; rst_n pulse clears both and returns to FETCH.
REQ-045 CNT_W=2, 5 instructions retired -> instr_count sequence 1,2,3,3,3.
